// File: rtl/unidad_ld_st_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Request side is level-held req/ack: address, data and enables stay stable until ack.
interface unidad_ld_st_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/unidad_ld_st.sv
// Load/store unit: IDLE->REQ->FIN, listo one cycle after mem_ack (min 2 cycles/txn); waits on mem_ack,
// start ignored while ocupado. Optional LSU_TIMEOUT_EN aborts REQ after TIMEOUT_CICLOS cycles.
module unidad_ld_st
`ifdef LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CICLOS = 16)
`endif
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  es_escritura,
  input  logic [2:0]            funct3,
  input  logic [31:0]           dir,
  input  logic [31:0]           dato_esc,
  output logic                  ocupado,
  output logic                  listo,
  output logic                  error,
  output logic [31:0]           dato_carga,
  unidad_ld_st_if.master        mem
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} estado_t;

  estado_t     estado_q, estado_d;
  logic        ocupado_q, ocupado_d;
  logic        listo_q, listo_d;
  logic        error_q, error_d;
  logic [31:0] dato_carga_q, dato_carga_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic        legal_f3, alineado;
  logic [3:0]  be_nuevo;
  logic [31:0] wdata_nuevo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] carga_ext;

  // Decode of the incoming request, evaluated only while IDLE.
  always_comb begin
    if (es_escritura)
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      legal_f3 = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
    alineado = 1'b1;
    case (funct3[1:0])
      2'b01:   alineado = ~dir[0];
      2'b10:   alineado = (dir[1:0] == 2'b00);
      default: alineado = 1'b1;
    endcase
    be_nuevo    = 4'b1111;
    wdata_nuevo = dato_esc;
    if (es_escritura) begin
      case (funct3[1:0])
        2'b00: begin
          be_nuevo    = 4'b0001 << dir[1:0];
          wdata_nuevo = {4{dato_esc[7:0]}};
        end
        2'b01: begin
          be_nuevo    = 4'b0011 << dir[1:0];
          wdata_nuevo = {2{dato_esc[15:0]}};
        end
        default: begin
          be_nuevo    = 4'b1111;
          wdata_nuevo = dato_esc;
        end
      endcase
    end
  end

  // Lane extraction uses the latched offset, not the live dir input.
  always_comb begin
    case (off_q)
      2'd1:    byte_sel = mem.mem_rdata[15:8];
      2'd2:    byte_sel = mem.mem_rdata[23:16];
      2'd3:    byte_sel = mem.mem_rdata[31:24];
      default: byte_sel = mem.mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  carga_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  carga_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  carga_ext = {24'd0, byte_sel};
      3'b101:  carga_ext = {16'd0, half_sel};
      default: carga_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    estado_d     = estado_q;
    ocupado_d    = ocupado_q;
    listo_d      = 1'b0;
    error_d      = 1'b0;
    dato_carga_d = dato_carga_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    off_d        = off_q;
    f3_d         = f3_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (estado_q)
      IDLE: begin
        if (start) begin
          ocupado_d = 1'b1;
          if (legal_f3 && alineado) begin
            estado_d    = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = es_escritura;
            mem_addr_d  = {dir[31:2], 2'b00};
            mem_wdata_d = wdata_nuevo;
            mem_be_d    = be_nuevo;
            off_d       = dir[1:0];
            f3_d        = funct3;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            estado_d = FIN;
            listo_d  = 1'b1;
            error_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          estado_d  = FIN;
          mem_req_d = 1'b0;
          listo_d   = 1'b1;
          if (!mem_we_q)
            dato_carga_d = carga_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CICLOS - 1)) begin
          estado_d  = FIN;
          mem_req_d = 1'b0;
          listo_d   = 1'b1;
          error_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      FIN: begin
        estado_d  = IDLE;
        ocupado_d = 1'b0;
      end
      default: begin
        estado_d  = IDLE;
        ocupado_d = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= IDLE;
      ocupado_q    <= 1'b0;
      listo_q      <= 1'b0;
      error_q      <= 1'b0;
      dato_carga_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      off_q        <= '0;
      f3_q         <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      estado_q     <= estado_d;
      ocupado_q    <= ocupado_d;
      listo_q      <= listo_d;
      error_q      <= error_d;
      dato_carga_q <= dato_carga_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ocupado       = ocupado_q;
  assign listo         = listo_q;
  assign error         = error_q;
  assign dato_carga    = dato_carga_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule
